// File: rtl/jtpang_bank_pkg.sv
// rtl/jtpang_bank_pkg.sv - shared types and constants for the four-bank read responder
package jtpang_bank_pkg;

   localparam int NBANK  = 4;
   localparam int DEF_AW = 22;
   localparam int DEF_DW = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_t;

   // Tag carried alongside each outstanding memory read until its word is delivered
   typedef struct packed {
      logic vld;
      logic first;
      logic last;
   } flight_t;

   function automatic int flight_w(input int mem_lat);
      return mem_lat + 1;
   endfunction

endpackage

// File: rtl/jtpang_bank_resp_if.sv
// rtl/jtpang_bank_resp_if.sv - four-bank SDRAM read request/response bundle
interface jtpang_bank_resp_if
   import jtpang_bank_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
);

   logic [AW-1:0]    ba0_addr;
   logic [AW-1:0]    ba1_addr;
   logic [AW-1:0]    ba2_addr;
   logic [AW-1:0]    ba3_addr;
   logic [NBANK-1:0] ba_rd;
   logic [NBANK-1:0] ba_ack;
   logic [NBANK-1:0] ba_dst;
   logic [NBANK-1:0] ba_dok;
   logic [NBANK-1:0] ba_rdy;
   logic [DW-1:0]    data_read;

   modport master (
      output ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd,
      input  ba_ack, ba_dst, ba_dok, ba_rdy, data_read
   );

   modport slave (
      input  ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd,
      output ba_ack, ba_dst, ba_dok, ba_rdy, data_read
   );

endinterface

// File: rtl/jtpang_bank_rr.sv
// rtl/jtpang_bank_rr.sv - four-input round-robin arbiter holding the last-grant pointer
module jtpang_bank_rr
   import jtpang_bank_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [NBANK-1:0] req,
   input  logic             update,
   output logic [NBANK-1:0] grant,
   output logic [1:0]       idx
);

   logic [1:0] last;
   logic [1:0] cand;
   logic       found;

   // Search starts one past the last winner, so a pointer of 3 favours bank 0
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= NBANK; i++) begin
         cand = last + 2'(i);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         last <= 2'd3;
      else if (update && found)
         last <= idx;
   end

endmodule

// File: rtl/jtpang_bank_resp.sv
// rtl/jtpang_bank_resp.sv - read-only four-bank SDRAM responder over a pipelined memory port
// Optional protocol checker on err is built with JTPANG_BANK_CHECK_EN.
module jtpang_bank_resp
   import jtpang_bank_pkg::*;
#(
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW,
   parameter int BURST   = 2,
   parameter int MEM_LAT = 2
)(
   input  logic          clk,
   input  logic          rst,
   jtpang_bank_resp_if.slave bank,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   input  logic [DW-1:0] mem_dout,
   output logic          busy,
   output logic          err
);

   localparam int         FW     = flight_w(MEM_LAT);
   localparam logic [1:0] LAST_K = 2'(BURST - 1);

   state_t             state, state_nx;
   logic [1:0]         cnt;
   logic [NBANK-1:0]   bank_oh;
   logic [NBANK-1:0]   ack_q;
   logic [AW-1:0]      addr_q;
   logic [AW-1:0]      addr_sel;
   logic [DW-1:0]      data_q;
   flight_t [FW-1:0]   flight;
   flight_t            head;
   flight_t            issue_tag;
   logic [NBANK-1:0]   rr_grant;
   logic [1:0]         rr_idx;
   logic               grant_go;

   jtpang_bank_rr u_rr (
      .clk    (clk),
      .rst    (rst),
      .req    (bank.ba_rd),
      .update (grant_go),
      .grant  (rr_grant),
      .idx    (rr_idx)
   );

   always_comb begin
      addr_sel = bank.ba0_addr;
      case (rr_idx)
         2'd1:    addr_sel = bank.ba1_addr;
         2'd2:    addr_sel = bank.ba2_addr;
         2'd3:    addr_sel = bank.ba3_addr;
         default: addr_sel = bank.ba0_addr;
      endcase
   end

   assign head = flight[MEM_LAT];

   always_comb begin
      state_nx = state;
      grant_go = 1'b0;
      case (state)
         IDLE: begin
            if (|bank.ba_rd) begin
               grant_go = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            if (cnt == LAST_K)
               state_nx = DRAIN;
         end
         DRAIN: begin
            if (head.vld && head.last)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      issue_tag       = '0;
      issue_tag.vld   = (state == ISSUE);
      issue_tag.first = (cnt == 2'd0);
      issue_tag.last  = (cnt == LAST_K);
   end

   // Tags shift one slot per cycle; slot MEM_LAT-1 lines up with mem_dout
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q   <= '0;
         bank_oh <= '0;
         addr_q  <= '0;
         cnt     <= '0;
         flight  <= '0;
         data_q  <= '0;
      end else begin
         ack_q <= grant_go ? rr_grant : '0;
         if (grant_go) begin
            bank_oh <= rr_grant;
            addr_q  <= addr_sel;
            cnt     <= '0;
         end else if (state == ISSUE) begin
            addr_q <= addr_q + AW'(1);
            cnt    <= cnt + 2'd1;
         end
         flight <= {flight[FW-2:0], issue_tag};
         if (flight[MEM_LAT-1].vld)
            data_q <= mem_dout;
      end
   end

   assign mem_rd         = (state == ISSUE);
   assign mem_addr       = addr_q;
   assign busy           = (state != IDLE);
   assign bank.ba_ack    = ack_q;
   assign bank.ba_dok    = head.vld ? bank_oh : '0;
   assign bank.ba_dst    = (head.vld && head.first) ? bank_oh : '0;
   assign bank.ba_rdy    = (head.vld && head.last) ? bank_oh : '0;
   assign bank.data_read = data_q;

`ifdef JTPANG_BANK_CHECK_EN
   logic [NBANK-1:0] rd_prev;
   logic [NBANK-1:0] acked;
   logic [NBANK-1:0] fell;
   logic [NBANK-1:0] moved;
   logic [AW-1:0]    addr_cur  [NBANK];
   logic [AW-1:0]    addr_prev [NBANK];
   logic             err_q;

   assign addr_cur[0] = bank.ba0_addr;
   assign addr_cur[1] = bank.ba1_addr;
   assign addr_cur[2] = bank.ba2_addr;
   assign addr_cur[3] = bank.ba3_addr;

   // A request is pending from its rise until its ack pulse
   always_comb begin
      fell  = '0;
      moved = '0;
      for (int i = 0; i < NBANK; i++) begin
         fell[i]  = rd_prev[i] && !bank.ba_rd[i] && !acked[i] && !ack_q[i];
         moved[i] = rd_prev[i] && bank.ba_rd[i] && !acked[i] && !ack_q[i]
                    && (addr_cur[i] != addr_prev[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_prev <= '0;
         acked   <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < NBANK; i++)
            addr_prev[i] <= '0;
      end else begin
         rd_prev <= bank.ba_rd;
         acked   <= (acked | ack_q) & bank.ba_rd;
         for (int i = 0; i < NBANK; i++)
            addr_prev[i] <= addr_cur[i];
         if (|(fell | moved))
            err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
